// File: rtl/pll_ctrl_pkg.sv
// pll_ctrl_pkg: shared state encodings and constants for the video PLL lock controller
package pll_ctrl_pkg;
  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } state_e;
  localparam logic [7:0] CNT_SAT = 8'hFF;
endpackage

// File: rtl/pll_video_lock_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous status bit, clears to 0 on reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/pll_video_lock_ctrl.sv
// pll_video_lock_ctrl: sequences video PLL reset, lock wait with retry, lock qualification and video reset release
module pll_video_lock_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 16
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart_req,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       ready,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_lost_cnt
);
  localparam logic [CNT_W-1:0] RST_END = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_END  = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] ST_END  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [7:0]       MAX_R   = 8'(MAX_RETRIES);
  logic             lk;
  logic [2:0]       st, st_nxt;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       retry_inc, retry_nxt, lost_nxt;
  sync_2ff u_sync (.clk(refclk), .rst_n(rst_n), .d(pll_locked), .q(lk));
  assign retry_inc = retry_cnt == CNT_SAT ? retry_cnt : retry_cnt + 8'd1;
  always_comb begin
    st_nxt    = st;
    retry_nxt = retry_cnt;
    lost_nxt  = lock_lost_cnt;
    if (restart_req) begin
      st_nxt    = HOLD;
      retry_nxt = '0;
    end else begin
      case (st)
        HOLD:      st_nxt = cnt == RST_END ? WAIT_LOCK : HOLD;
        WAIT_LOCK: begin
          if (lk) st_nxt = STABLE;
          else if (cnt == TO_END) begin
            retry_nxt = retry_inc;
            st_nxt    = retry_inc >= MAX_R ? FAIL : HOLD;
          end
        end
        STABLE: begin
          if (!lk) st_nxt = WAIT_LOCK;
          else if (cnt == ST_END) begin
            st_nxt    = RUN;
            retry_nxt = '0;
          end
        end
        RUN: begin
          if (!lk) begin
            st_nxt   = HOLD;
            lost_nxt = lock_lost_cnt == CNT_SAT ? lock_lost_cnt : lock_lost_cnt + 8'd1;
          end
        end
        FAIL:    st_nxt = FAIL;
        default: st_nxt = HOLD;
      endcase
    end
  end
  always_ff @(posedge refclk or negedge rst_n)
    if (!rst_n) begin
      st            <= HOLD;
      cnt           <= '0;
      retry_cnt     <= '0;
      lock_lost_cnt <= '0;
    end else begin
      st            <= st_nxt;
      cnt           <= (st_nxt != st || restart_req) ? '0 : cnt + CNT_W'(1);
      retry_cnt     <= retry_nxt;
      lock_lost_cnt <= lost_nxt;
    end
  assign state       = st;
  assign pll_rst     = !(st == WAIT_LOCK || st == STABLE || st == RUN);
  assign video_rst_n = st == RUN;
  assign ready       = st == RUN;
  assign fail        = st == FAIL;
endmodule

// File: tb/tb_pll_video_lock_ctrl.sv
// tb_pll_video_lock_ctrl: vector table, corner sequences and randomized model comparison for the PLL lock controller
module tb_pll_video_lock_ctrl;
  import pll_ctrl_pkg::*;
  logic       refclk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, restart_req = 1'b0;
  logic       pll_rst, video_rst_n, ready, fail;
  logic [2:0] state;
  logic [7:0] retry_cnt, lock_lost_cnt;
  logic [22:0] act;
  int checks = 0, failures = 0, cyc = 0, run = 0;
  typedef struct {
    logic       lck;
    logic       rq;
    int         n;
    logic [2:0] st;
    logic [7:0] r;
    logic [7:0] l;
  } vec_t;
  vec_t tbl[$];
  state_e m_ph;
  int     m_dl, m_rty, m_lost;
  logic   lkq[$];
  always #5 refclk = ~refclk;
  pll_video_lock_ctrl #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(64), .STABLE_CYCLES(16), .MAX_RETRIES(3), .CNT_W(16)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked), .restart_req(restart_req),
    .pll_rst(pll_rst), .video_rst_n(video_rst_n), .ready(ready), .fail(fail),
    .state(state), .retry_cnt(retry_cnt), .lock_lost_cnt(lock_lost_cnt)
  );
  assign act = {state, retry_cnt, lock_lost_cnt, pll_rst, video_rst_n, ready, fail};
  function automatic logic [22:0] exp_of(logic [2:0] s, logic [7:0] r, logic [7:0] l);
    return {s, r, l, s == HOLD || s == FAIL, s == RUN, s == RUN, s == FAIL};
  endfunction
  task automatic check(string nm, logic [22:0] got, logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got st=%0d retry=%0d lost=%0d rst/vrst_n/rdy/fail=%b want st=%0d retry=%0d lost=%0d rst/vrst_n/rdy/fail=%b",
               nm, cyc, got[22:20], got[19:12], got[11:4], got[3:0], exp[22:20], exp[19:12], exp[11:4], exp[3:0]);
    end
  endtask
  task automatic step();
    @(posedge refclk);
    #1;
    cyc++;
  endtask
  task automatic add(logic lck, logic rq, int n, logic [2:0] s, logic [7:0] r, logic [7:0] l);
    tbl.push_back('{lck, rq, n, s, r, l});
  endtask
  task automatic model_enter(state_e p);
    m_ph = p;
    m_dl = cyc + (p == HOLD ? 4 : p == WAIT_LOCK ? 64 : 16);
  endtask
  task automatic model_reset();
    cyc = 0;
    m_rty = 0;
    m_lost = 0;
    lkq = '{1'b0, 1'b0};
    model_enter(HOLD);
  endtask
  task automatic model_edge(logic lck, logic rq);
    logic lk = lkq.pop_front();
    lkq.push_back(lck);
    if (rq) begin
      m_rty = 0;
      model_enter(HOLD);
    end else if (m_ph == HOLD && cyc == m_dl) model_enter(WAIT_LOCK);
    else if (m_ph == WAIT_LOCK && lk) model_enter(STABLE);
    else if (m_ph == WAIT_LOCK && cyc == m_dl) begin
      m_rty = m_rty >= 255 ? 255 : m_rty + 1;
      model_enter(m_rty >= 3 ? FAIL : HOLD);
    end else if (m_ph == STABLE && !lk) model_enter(WAIT_LOCK);
    else if (m_ph == STABLE && cyc == m_dl) begin
      m_rty = 0;
      model_enter(RUN);
    end else if (m_ph == RUN && !lk) begin
      m_lost = m_lost >= 255 ? 255 : m_lost + 1;
      model_enter(HOLD);
    end
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    pll_locked = 1'b0;
    restart_req = 1'b0;
    step();
    step();
    check("reset", act, exp_of(HOLD, 0, 0));
    rst_n = 1'b1;
    model_reset();
  endtask
  initial begin
    add(0, 0, 3, HOLD, 0, 0);
    add(0, 0, 1, WAIT_LOCK, 0, 0);
    add(1, 0, 2, WAIT_LOCK, 0, 0);
    add(1, 0, 1, STABLE, 0, 0);
    add(1, 0, 15, STABLE, 0, 0);
    add(1, 0, 1, RUN, 0, 0);
    add(0, 0, 2, RUN, 0, 0);
    add(0, 0, 1, HOLD, 0, 1);
    add(0, 0, 3, HOLD, 0, 1);
    add(0, 0, 1, WAIT_LOCK, 0, 1);
    add(1, 0, 2, WAIT_LOCK, 0, 1);
    add(1, 0, 1, STABLE, 0, 1);
    add(1, 0, 8, STABLE, 0, 1);
    add(0, 0, 2, STABLE, 0, 1);
    add(0, 0, 1, WAIT_LOCK, 0, 1);
    add(1, 0, 2, WAIT_LOCK, 0, 1);
    add(1, 0, 1, STABLE, 0, 1);
    add(1, 0, 15, STABLE, 0, 1);
    add(1, 0, 1, RUN, 0, 1);
    add(0, 1, 1, HOLD, 0, 1);
    for (int a = 0; a < 3; a++) begin
      add(0, 0, 3, HOLD, 8'(a), 1);
      add(0, 0, 64, WAIT_LOCK, 8'(a), 1);
      add(0, 0, 1, a == 2 ? FAIL : HOLD, 8'(a + 1), 1);
    end
    add(0, 0, 1000, FAIL, 3, 1);
    add(0, 1, 1, HOLD, 0, 1);
    add(0, 0, 3, HOLD, 0, 1);
    add(0, 0, 64, WAIT_LOCK, 0, 1);
    add(0, 1, 1, HOLD, 0, 1);
    add(0, 0, 3, HOLD, 0, 1);
    add(0, 0, 1, WAIT_LOCK, 0, 1);
    reset_dut();
    foreach (tbl[i])
      for (int k = 0; k < tbl[i].n; k++) begin
        pll_locked = tbl[i].lck;
        restart_req = tbl[i].rq && k == 0;
        step();
        check($sformatf("vec%0d", i), act, exp_of(tbl[i].st, tbl[i].r, tbl[i].l));
      end
    restart_req = 1'b0;
    reset_dut();
    run = 0;
    for (int c = 0; c < 15000; c++) begin
      if (run == 0) begin
        pll_locked = !pll_locked;
        run = pll_locked ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 200));
      end
      run--;
      restart_req = $urandom_range(0, 299) == 0;
      step();
      model_edge(pll_locked, restart_req);
      check("rand", act, exp_of(m_ph, 8'(m_rty), 8'(m_lost)));
    end
    restart_req = 1'b0;
    reset_dut();
    pll_locked = 1'b1;
    repeat (30) step();
    check("run_before_async_rst", act, exp_of(RUN, 0, 0));
    #2 rst_n = 1'b0;
    #1 check("async_rst", act, exp_of(HOLD, 0, 0));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 258; i++) begin
      pll_locked = 1'b1;
      repeat (30) step();
      check("sat_run", act, exp_of(RUN, 0, 8'(i > 255 ? 255 : i)));
      pll_locked = 1'b0;
      repeat (4) step();
      check("sat_lost", act, exp_of(HOLD, 0, 8'(i + 1 > 255 ? 255 : i + 1)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
